vend_ctrl_multi: RTL
====================

Name: vend_ctrl_multi

Overview:
- Parametrised successor to the single-shot vending FSM.
- Supports N selectable items, each with a per-item price, a per-item stock counter and sold-out flags.
- Accumulates multiple coin insertions, with cancel/refund and an inactivity timeout.
- Sits between the keypad/coin-acceptor front end and the dispense/change actuators; all outputs are registered.

Parameters:
- N_ITEMS, 4, number of selectable items
- SEL_W, 2, width of item index (>= clog2(N_ITEMS))
- AMT_W, 8, width of coin, credit, price and change values
- PRICES, {8'd10,8'd8,8'd5,8'd3}, packed N_ITEMS*AMT_W price table; item i at bits [i*AMT_W +: AMT_W]
- STOCK_W, 4, width of each stock counter
- STOCK_INIT, 3, stock loaded into every item at reset and on restock
- TIMEOUT, 255, idle cycles in COLLECT before automatic refund (>= 1)

Ports:
- clk  input  1  system clock, rising edge
- b1  input  1  reset; synchronous, active-low
- sel_valid  input  1  selection strobe, one cycle
- sel  input  SEL_W  item index, qualified by sel_valid
- coin_valid  input  1  coin strobe, one cycle
- coin  input  AMT_W  coin value, qualified by coin_valid
- cancel  input  1  request refund of current credit
- restock  input  1  reload all stock counters
- vend  output  1  dispense pulse, one cycle
- vend_item  output  SEL_W  item dispensed, valid while vend=1
- change_valid  output  1  change/refund pulse, one cycle
- change  output  AMT_W  amount returned, valid while change_valid=1
- credit  output  AMT_W  current accumulated credit
- sold_out  output  N_ITEMS  bit i=1 when stock[i]==0
- err  output  1  one-cycle pulse on rejected request
- busy  output  1  1 in every state except IDLE

Behaviour:
- Reset (b1=0 at a clk edge):
  - state=IDLE.
  - credit, change, vend, vend_item, change_valid, err, timeout counter = 0.
  - All stock = STOCK_INIT; sold_out recomputed (all 0 if STOCK_INIT>0).
  - Reset overrides every other input, including mid-transaction: credit is discarded, no refund pulse.
- States: IDLE, COLLECT, VEND, CHANGE, REFUND.
- IDLE:
  - sel_valid with sel<N_ITEMS and stock[sel]>0: latch item and price, go to COLLECT, clear timeout counter.
  - sel_valid with sel>=N_ITEMS or stock[sel]==0: err=1 next cycle, stay IDLE.
  - coin_valid: coin rejected, err=1, credit unchanged.
  - cancel: ignored.
  - restock: all stock = STOCK_INIT. restock is honoured only in IDLE and ignored elsewhere.
- COLLECT:
  - coin_valid: credit <= sat(credit+coin), saturating at 2^AMT_W-1; timeout counter cleared.
  - If the new credit >= price, go to VEND on the same edge. vend is seen the cycle after the qualifying coin.
  - cancel (with or without a simultaneous coin): coin is added first, then go to REFUND. cancel has priority over reaching price.
  - sel_valid: ignored, err=1.
  - No coin: timeout counter increments. When it reaches TIMEOUT, go to REFUND.
- VEND (one cycle):
  - vend=1, vend_item=latched item.
  - stock[item] decrements; it never underflows because entry requires stock>0.
  - Go to CHANGE.
- CHANGE (one cycle): change_valid=1, change=credit-price (may be 0; pulse still asserted), credit<=0, go to IDLE.
- REFUND (one cycle): change_valid=1, change=credit (may be 0), credit<=0, go to IDLE.
- In VEND, CHANGE and REFUND, all inputs except b1 are ignored. A coin arriving then is dropped and err=1.
- Outputs in other states: change holds its last value when change_valid=0. vend and change_valid are never high in the same cycle.
- Transaction latency, exact-price single coin: sel edge t0, coin edge t1, vend in cycle after t1, change_valid one cycle later, IDLE one cycle after that.

Test Plan:
- Reset, sel=1 (price 5), coins 2,2,1 on consecutive cycles -> vend=1 with vend_item=1 the cycle after the third coin; next cycle change_valid=1, change=0; stock[1]=2.
- sel=3 (price 10), single coin 25 -> vend=1, vend_item=3, then change_valid=1, change=15, credit=0.
- sel=2, coin 4, then cancel on the same cycle as coin 3 -> no vend; change_valid=1, change=7.
- sel=0, coin 1, then 255 idle cycles -> REFUND with change=1; coin 200 then 100 in COLLECT of a non-terminating case shows credit saturating at 255.
- Buy item 0 three times -> sold_out[0]=1; sel=0 -> err pulse, stays IDLE; restock -> sold_out[0]=0 and selection accepted.
- b1=0 while in COLLECT with credit=6 -> next cycle IDLE, credit=0, no change_valid, all stock=3.

Source files
------------

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: per-item price and stock, multi-coin credit,
// cancel/refund and idle-timeout refund. All outputs are registered.
module vend_ctrl_multi #(
    parameter int                         N_ITEMS    = 4,
    parameter int                         SEL_W      = 2,
    parameter int                         AMT_W      = 8,
    parameter logic [N_ITEMS*AMT_W-1:0]   PRICES     = {8'd10, 8'd8, 8'd5, 8'd3},
    parameter int                         STOCK_W    = 4,
    parameter int                         STOCK_INIT = 3,
    parameter int                         TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 b1,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 coin_valid,
    input  logic [AMT_W-1:0]     coin,
    input  logic                 cancel,
    input  logic                 restock,
    output logic                 vend,
    output logic [SEL_W-1:0]     vend_item,
    output logic                 change_valid,
    output logic [AMT_W-1:0]     change,
    output logic [AMT_W-1:0]     credit,
    output logic [N_ITEMS-1:0]   sold_out,
    output logic                 err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3,
        REFUND  = 3'd4
    } state_t;

    localparam int                 CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [STOCK_W-1:0] STOCK_LD = STOCK_W'(STOCK_INIT);

    function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                                 input logic [AMT_W-1:0] b);
        logic [AMT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[AMT_W]) begin
            return {AMT_W{1'b1}};
        end else begin
            return sum[AMT_W-1:0];
        end
    endfunction

    state_t               state_r;
    logic [SEL_W-1:0]     item_r;
    logic [AMT_W-1:0]     price_r;
    logic [CNT_W-1:0]     tcnt_r;
    logic [STOCK_W-1:0]   stock_r [N_ITEMS];

    logic                 sel_ok_s;
    logic [AMT_W-1:0]     sel_price_s;
    logic [AMT_W-1:0]     credit_new_s;

    // Selection lookup against the price table and live stock, plus the post-coin credit.
    always_comb begin
        sel_ok_s    = 1'b0;
        sel_price_s = {AMT_W{1'b0}};
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_price_s = PRICES[i*AMT_W +: AMT_W];
                sel_ok_s    = (stock_r[i] != {STOCK_W{1'b0}});
            end else begin
                sel_ok_s    = sel_ok_s;
            end
        end
        if (coin_valid) begin
            credit_new_s = sat_add(credit, coin);
        end else begin
            credit_new_s = credit;
        end
    end

    // Transaction FSM with registered outputs and stock bookkeeping.
    always_ff @(posedge clk) begin
        if (!b1) begin
            state_r      <= IDLE;
            item_r       <= {SEL_W{1'b0}};
            price_r      <= {AMT_W{1'b0}};
            tcnt_r       <= {CNT_W{1'b0}};
            credit       <= {AMT_W{1'b0}};
            change       <= {AMT_W{1'b0}};
            vend         <= 1'b0;
            vend_item    <= {SEL_W{1'b0}};
            change_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_r[i] <= STOCK_LD;
            end
            sold_out     <= {N_ITEMS{STOCK_LD == {STOCK_W{1'b0}}}};
        end else begin
            vend         <= 1'b0;
            change_valid <= 1'b0;
            err          <= 1'b0;
            case (state_r)
                IDLE: begin
                    busy <= 1'b0;
                    if (coin_valid) begin
                        err <= 1'b1;
                    end else begin
                        err <= 1'b0;
                    end
                    if (sel_valid) begin
                        if (sel_ok_s) begin
                            item_r  <= sel;
                            price_r <= sel_price_s;
                            tcnt_r  <= {CNT_W{1'b0}};
                            busy    <= 1'b1;
                            state_r <= COLLECT;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                    if (restock) begin
                        for (int i = 0; i < N_ITEMS; i++) begin
                            stock_r[i] <= STOCK_LD;
                        end
                        sold_out <= {N_ITEMS{STOCK_LD == {STOCK_W{1'b0}}}};
                    end else begin
                        sold_out <= sold_out;
                    end
                end
                COLLECT: begin
                    err    <= sel_valid;
                    credit <= credit_new_s;
                    // Cancel wins over reaching the price, but any coin on that edge still counts.
                    if (cancel) begin
                        change_valid <= 1'b1;
                        change       <= credit_new_s;
                        state_r      <= REFUND;
                    end else if (credit_new_s >= price_r) begin
                        vend      <= 1'b1;
                        vend_item <= item_r;
                        state_r   <= VEND;
                    end else if (coin_valid) begin
                        tcnt_r <= {CNT_W{1'b0}};
                    end else if (tcnt_r == TO_LAST) begin
                        change_valid <= 1'b1;
                        change       <= credit;
                        state_r      <= REFUND;
                    end else begin
                        tcnt_r <= tcnt_r + CNT_W'(1);
                    end
                end
                VEND: begin
                    err          <= coin_valid;
                    change_valid <= 1'b1;
                    change       <= credit - price_r;
                    state_r      <= CHANGE;
                    for (int i = 0; i < N_ITEMS; i++) begin
                        if (item_r == SEL_W'(i)) begin
                            stock_r[i]  <= stock_r[i] - STOCK_W'(1);
                            sold_out[i] <= (stock_r[i] == STOCK_W'(1));
                        end else begin
                            stock_r[i]  <= stock_r[i];
                        end
                    end
                end
                CHANGE, REFUND: begin
                    err     <= coin_valid;
                    credit  <= {AMT_W{1'b0}};
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    credit  <= {AMT_W{1'b0}};
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
